// File: rtl/gene_sweep_ctrl_if.sv
// Result record channel of the gene-network sweep controller.
// Valid/ready handshake carrying one fixed-point search finding.
interface gene_sweep_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_init;
  logic [WIDTH-1:0] res_state;
  logic [1:0]       res_kind;
  logic [7:0]       res_steps;

  modport master (
    output res_valid,
    output res_init,
    output res_state,
    output res_kind,
    output res_steps,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_init,
    input  res_state,
    input  res_kind,
    input  res_steps,
    output res_ready
  );
endinterface

// File: rtl/gene_sweep_ctrl.sv
// Sweeps initial gene states, runs the network to a fixed point or timeout.
// Optional period-2 detection is enabled by defining CYCLE2_DETECT_EN.
module gene_sweep_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_STEPS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] first_init,
  input  logic [WIDTH-1:0] last_init,
  output logic             net_load,
  output logic [WIDTH-1:0] net_init,
  output logic             net_step,
  input  logic [WIDTH-1:0] net_state,
  output logic             busy,
  output logic             done,
  gene_sweep_ctrl_if.master res
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    REPORT
  } state_e;

  localparam logic [7:0] MaxSteps = 8'(MAX_STEPS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [7:0]       steps_q, steps_d;
  logic [WIDTH-1:0] rinit_q, rinit_d;
  logic [WIDTH-1:0] rstate_q, rstate_d;
  logic [1:0]       rkind_q, rkind_d;
  logic [7:0]       rsteps_q, rsteps_d;
  logic             done_q, done_d;

  logic fix_hit;
  logic c2_hit;
  logic to_hit;

`ifdef CYCLE2_DETECT_EN
  logic [WIDTH-1:0] prev2_q, prev2_d;
  logic             prev2_valid_q, prev2_valid_d;

  assign c2_hit = prev2_valid_q && (net_state == prev2_q);
`else
  assign c2_hit = 1'b0;
`endif

  assign fix_hit = prev_valid_q && (net_state == prev_q);
  assign to_hit  = (steps_q == MaxSteps);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    steps_d      = steps_q;
    rinit_d      = rinit_q;
    rstate_d     = rstate_q;
    rkind_d      = rkind_q;
    rsteps_d     = rsteps_q;
    done_d       = 1'b0;
    net_load     = 1'b0;
    net_init     = '0;
    net_step     = 1'b0;
`ifdef CYCLE2_DETECT_EN
    prev2_d       = prev2_q;
    prev2_valid_d = prev2_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_init;
          last_d  = last_init;
          state_d = LOAD;
        end
      end
      LOAD: begin
        net_load     = 1'b1;
        net_init     = cur_q;
        steps_d      = '0;
        prev_valid_d = 1'b0;
`ifdef CYCLE2_DETECT_EN
        prev2_valid_d = 1'b0;
`endif
        state_d = RUN;
      end
      RUN: begin
        if (fix_hit || c2_hit || to_hit) begin
          rinit_d  = cur_q;
          rstate_d = net_state;
          rsteps_d = steps_q;
          // fixed point outranks period-2, which outranks timeout
          rkind_d  = fix_hit ? 2'b00 : (c2_hit ? 2'b10 : 2'b01);
          state_d  = REPORT;
        end else begin
          net_step     = 1'b1;
          prev_d       = net_state;
          prev_valid_d = 1'b1;
          steps_d      = steps_q + 8'd1;
`ifdef CYCLE2_DETECT_EN
          prev2_d       = prev_q;
          prev2_valid_d = prev_valid_q;
`endif
        end
      end
      REPORT: begin
        if (res.res_ready) begin
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      steps_q      <= '0;
      rinit_q      <= '0;
      rstate_q     <= '0;
      rkind_q      <= '0;
      rsteps_q     <= '0;
      done_q       <= 1'b0;
`ifdef CYCLE2_DETECT_EN
      prev2_q       <= '0;
      prev2_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      steps_q      <= steps_d;
      rinit_q      <= rinit_d;
      rstate_q     <= rstate_d;
      rkind_q      <= rkind_d;
      rsteps_q     <= rsteps_d;
      done_q       <= done_d;
`ifdef CYCLE2_DETECT_EN
      prev2_q       <= prev2_d;
      prev2_valid_q <= prev2_valid_d;
`endif
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign res.res_valid = (state_q == REPORT);
  assign res.res_init  = rinit_q;
  assign res.res_state = rstate_q;
  assign res.res_kind  = rkind_q;
  assign res.res_steps = rsteps_q;

endmodule

// File: tb/tb_gene_sweep_ctrl.sv
// Bench for gene_sweep_ctrl: directed vector table, stall/reset sequences,
// and randomized sweeps against a trajectory-based reference model.
module tb_gene_sweep_ctrl;
  localparam int W    = 8;
  localparam int MAXS = 64;

  typedef struct packed {
    logic [7:0] init;
    logic [7:0] state;
    logic [1:0] kind;
    logic [7:0] steps;
  } rec_t;

  typedef struct {
    int         mode;
    logic [7:0] f;
    logic [7:0] l;
    int         n;
    rec_t       r0;
    int         ns;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] first_init;
  logic [7:0] last_init;
  logic       net_load;
  logic [7:0] net_init;
  logic       net_step;
  logic [7:0] net_state;
  logic       busy;
  logic       done;

  gene_sweep_ctrl_if #(.WIDTH(W)) rif ();

  gene_sweep_ctrl #(
    .WIDTH(W),
    .MAX_STEPS(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .first_init(first_init),
    .last_init(last_init),
    .net_load(net_load),
    .net_init(net_init),
    .net_step(net_step),
    .net_state(net_state),
    .busy(busy),
    .done(done),
    .res(rif)
  );

  always #5 clk = ~clk;

`ifdef CYCLE2_DETECT_EN
  localparam bit C2 = 1'b1;
`else
  localparam bit C2 = 1'b0;
`endif

  int         mode;
  logic [7:0] tbl [256];
  logic [7:0] x = 8'd0;
  rec_t       recs [$];
  int         nsteps;
  int         ndone;
  int         checks;
  int         errors;

  function automatic logic [7:0] fnet(input logic [7:0] v);
    case (mode)
      0:       return v;
      1:       return v + 8'd1;
      2:       return ~v;
      3:       return v >> 1;
      default: return tbl[v];
    endcase
  endfunction

  // external gene-state register
  always @(posedge clk) begin
    if (net_load)      x <= net_init;
    else if (net_step) x <= fnet(x);
  end
  assign net_state = x;

  always @(negedge clk) begin
    if (!rst) begin
      if (rif.res_valid && rif.res_ready)
        recs.push_back('{rif.res_init, rif.res_state, rif.res_kind, rif.res_steps});
      if (net_step) nsteps++;
      if (done) ndone++;
      if (net_load && net_step) begin
        checks++;
        errors++;
        $display("FAIL load_step_overlap act=1 exp=0");
      end
    end
  end

  // trajectory s[k] = f^k(init); first k meeting a stop rule ends the search
  function automatic rec_t ref_run(input logic [7:0] init);
    logic [7:0] s [0:MAXS];
    s[0] = init;
    for (int k = 0; k <= MAXS; k++) begin
      if (k > 0) s[k] = fnet(s[k-1]);
      if (k >= 1 && s[k] == s[k-1]) return '{init, s[k], 2'b00, 8'(k)};
      if (C2 && k >= 2 && s[k] == s[k-2]) return '{init, s[k], 2'b10, 8'(k)};
      if (k == MAXS) return '{init, s[k], 2'b01, 8'(k)};
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int md, input logic [7:0] f, input logic [7:0] l,
                              input int n, input logic [7:0] i0, input logic [7:0] s0,
                              input logic [1:0] k0, input logic [7:0] st0, input int ns);
    vec_t v;
    v.mode = md;
    v.f    = f;
    v.l    = l;
    v.n    = n;
    v.r0   = '{i0, s0, k0, st0};
    v.ns   = ns;
    return v;
  endfunction

  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input bit rnd);
    bit got;
    int n;
    int sum;
    rec_t e;
    recs.delete();
    nsteps = 0;
    ndone  = 0;
    got    = 1'b0;
    @(posedge clk);
    #1;
    first_init    = f;
    last_init     = l;
    start         = 1'b1;
    rif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      rif.res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("sweep_done_seen", 64'(got), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("sweep_busy_after", 64'(busy), 64'd0);
    chk("sweep_done_count", 64'(ndone), 64'd1);
    n   = int'(8'(l - f)) + 1;
    sum = 0;
    chk("sweep_rec_count", 64'(recs.size()), 64'(n));
    for (int i = 0; i < n && i < recs.size(); i++) begin
      e = ref_run(8'(f + 8'(i)));
      sum += int'(e.steps);
      chk("sweep_record", 64'(recs[i]), 64'(e));
    end
    if (recs.size() == n) chk("sweep_step_pulses", 64'(nsteps), 64'(sum));
  endtask

  vec_t vt [5];
  rec_t snap;
  bit   seen;

  initial begin
    checks        = 0;
    errors        = 0;
    mode          = 0;
    rst           = 1'b1;
    start         = 1'b0;
    first_init    = '0;
    last_init     = '0;
    rif.res_ready = 1'b0;
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);

    vt[0] = mk(0, 8'd3, 8'd3, 1, 8'd3, 8'd3, 2'b00, 8'd1, 1);
    vt[1] = mk(1, 8'd0, 8'd0, 1, 8'd0, 8'd64, 2'b01, 8'd64, 64);
    if (C2) vt[2] = mk(2, 8'h0F, 8'h0F, 1, 8'h0F, 8'h0F, 2'b10, 8'd2, 2);
    else    vt[2] = mk(2, 8'h0F, 8'h0F, 1, 8'h0F, 8'h0F, 2'b01, 8'd64, 64);
    vt[3] = mk(3, 8'h80, 8'h80, 1, 8'h80, 8'h00, 2'b00, 8'd9, 9);
    vt[4] = mk(0, 8'd254, 8'd1, 4, 8'd254, 8'd254, 2'b00, 8'd1, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({net_load, net_step, net_init, busy, done, rif.res_valid,
             rif.res_init, rif.res_state, rif.res_kind, rif.res_steps}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mode = vt[i].mode;
      run_sweep(vt[i].f, vt[i].l, 1'b0);
      chk("vec_rec_count", 64'(recs.size()), 64'(vt[i].n));
      if (recs.size() > 0) chk("vec_first_record", 64'(recs[0]), 64'(vt[i].r0));
      chk("vec_step_pulses", 64'(nsteps), 64'(vt[i].ns));
    end

    // consumer stalls for five cycles in REPORT
    mode = 0;
    recs.delete();
    ndone = 0;
    @(posedge clk);
    #1;
    first_init    = 8'd5;
    last_init     = 8'd5;
    start         = 1'b1;
    rif.res_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rif.res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_valid_rise", 64'(seen), 64'd1);
    snap = '{rif.res_init, rif.res_state, rif.res_kind, rif.res_steps};
    chk("stall_record", 64'(snap), 64'({8'd5, 8'd5, 2'b00, 8'd1}));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_hold",
          64'({rif.res_valid, net_load, net_step, rif.res_init, rif.res_state,
               rif.res_kind, rif.res_steps}),
          64'({1'b1, 1'b0, 1'b0, snap}));
    end
    @(posedge clk);
    #1;
    rif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_valid_fall", 64'(rif.res_valid), 64'd0);
    chk("stall_done_pulse", 64'(done), 64'd1);
    chk("stall_accept_count", 64'(recs.size()), 64'd1);

    // reset in the middle of a run
    mode = 1;
    @(posedge clk);
    #1;
    first_init = 8'd0;
    last_init  = 8'd0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    ndone = 0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort",
        64'({busy, rif.res_valid, done, net_step, net_load}), 64'd0);
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(ndone), 64'd0);
    chk("rst_stay_idle", 64'(busy), 64'd0);
    mode = 0;
    run_sweep(8'd7, 8'd7, 1'b0);

    for (int t = 0; t < 12; t++) begin
      logic [7:0] f0;
      mode = int'($urandom_range(0, 4));
      for (int i = 0; i < 256; i++)
        tbl[i] = ($urandom_range(0, 3) == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      f0 = 8'($urandom_range(0, 255));
      run_sweep(f0, 8'(f0 + 8'($urandom_range(0, 4))), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gene_sweep_ctrl.md
# gene_sweep_ctrl

Sweep controller for the gene-network fixed-point search. It steps through a range of initial gene states and, for each one, loads the state into the external gene-state register. It then clocks the network one transition per cycle and watches for a fixed point (x[t] == x[t-1]) or a step-budget timeout. Each finding is reported as a result record over a valid/ready handshake. The block sits between the network datapath and the result logger/display.

## Interface
- WIDTH, 8, gene-state width in bits
- MAX_STEPS, 64, step budget per initial state; 1..255
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- first_init  in  WIDTH  first initial state; latched on start
- last_init  in  WIDTH  last initial state; latched on start
- net_load  out  1  load net_init into the gene-state register this edge
- net_init  out  WIDTH  initial state to load
- net_step  out  1  advance the network one transition this edge
- net_state  in  WIDTH  current gene-state register value, x[t]
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_init  out  WIDTH  initial state of this record
- res_state  out  WIDTH  net_state at termination
- res_kind  out  2  00 fixed point, 01 timeout, 10 period-2 cycle, 11 unused
- res_steps  out  8  net_step pulses issued for this initial state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sweep completes

## Operation
- External register contract: on the edge where net_load=1 it takes net_init. On the edge where net_step=1 it takes f(net_state). net_load and net_step are never high together.
- FSM states: IDLE, LOAD, RUN, REPORT.
- IDLE: start=1 latches cur=first_init, last=last_init and moves to LOAD. All other inputs are ignored.
- LOAD: net_load=1, net_init=cur. On exit: steps=0, prev_valid=0. Next state is RUN.
- RUN, evaluated each cycle in priority order:
  - prev_valid && net_state==prev: terminate with kind 00.
  - (CYCLE2_DETECT_EN only) prev2_valid && net_state==prev2: terminate with kind 10.
  - steps==MAX_STEPS: terminate with kind 01.
  - Otherwise: net_step=1, prev2<=prev, prev<=net_state, valid flags shift, steps+=1.
- Termination cycle: net_step=0. res_init<=cur, res_state<=net_state, res_kind and res_steps<=steps are latched. Next state is REPORT.
- REPORT: res_valid=1 and all res_* stay stable until res_ready=1. On the handshake:
  - cur==last: pulse done, go to IDLE.
  - Otherwise: cur<=cur+1 (mod 2^WIDTH), go to LOAD.
- Range wrap: first_init > last_init sweeps upward through 2^WIDTH-1 to 0. first_init == last_init produces exactly one record.
- start while busy has no effect.

## Timing
- Reset values: res_valid=0, res_* = 0, net_load=0, net_step=0, net_init=0, busy=0, done=0, FSM=IDLE.
- rst mid-sweep aborts to IDLE next edge. A pending record is dropped and no done pulse is issued.
- Per-init latency: 1 LOAD cycle, then steps+1 RUN cycles, then at least 1 REPORT cycle. With res_ready held high, a fixed-at-load state takes 4 cycles from LOAD to the next LOAD.
- res_valid rises the cycle after termination. It falls the cycle after the handshake.
- done is asserted in the cycle after the final handshake, together with the IDLE entry.
- The fixed-point comparison is against the registered prev. A state that is already fixed therefore reports steps=1.

## Configuration
- CYCLE2_DETECT_EN defined: prev2 register present. A period-2 oscillation reports kind 10. Fixed point has priority over period-2.
- CYCLE2_DETECT_EN undefined: no prev2 register. Oscillations run to MAX_STEPS and report kind 01. Kind 10 is never produced.

## Test plan
- Identity network, first=last=3, res_ready=1 -> one record: init 3, state 3, kind 00, steps 1; done pulse; busy low afterward.
- f(x)=x+1, MAX_STEPS=64, first=last=0 -> kind 01, steps 64, state 64; exactly 64 net_step pulses.
- f(x)=~x, first=last=0x0F:
  - With CYCLE2_DETECT_EN -> kind 10, steps 2, state 0x0F.
  - Without it -> kind 01, steps 64.
- Identity network, res_ready low for 5 cycles in REPORT -> res_valid and res_* stable; no net_load or net_step; record accepted on the first ready cycle.
- Range first=254, last=1 -> four records with res_init 254, 255, 0, 1 in order; one done pulse after the fourth.
- rst asserted during RUN -> next cycle FSM=IDLE, busy=0, res_valid=0, no done pulse. A new start then sweeps normally.
